hilo_muldiv_unit: RTL and testbench
===================================

// Module: hilo_muldiv_unit
// PURPOSE
//  Iterative multiply/divide engine owning the architectural HI/LO registers of the MIPS datapath.
//  Sits upstream of the second-operand selector: its hi/lo outputs feed that mux's HI and LO inputs
//  (read by MFHI/MFLO paths). Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from decode.
//  Uses a start/busy/done handshake so the pipeline can stall on HI/LO hazards.
// PARAMETERS
//  WIDTH  32  operand width; HI and LO are each WIDTH bits; iteration count = WIDTH
// PORTS
//  clk     in   1      single clock, all state on rising edge
//  rst_n   in   1      asynchronous, active-low reset
//  start   in   1      request; sampled only when busy=0
//  op      in   3      000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op
//  rs_val  in   WIDTH  operand A (dividend / multiplicand / MTHI-MTLO source)
//  rt_val  in   WIDTH  operand B (divisor / multiplier)
//  flush   in   1      abort the in-flight operation (pipeline squash)
//  busy    out  1      operation in progress; start ignored while 1
//  done    out  1      one-cycle pulse: hi/lo hold the new result
//  hi      out  WIDTH  HI register (product[2W-1:W] / remainder)
//  lo      out  WIDTH  LO register (product[W-1:0] / quotient)
// BEHAVIOUR
//  - Reset (async, rst_n=0): hi=0, lo=0, busy=0, done=0, FSM=IDLE, counter=0.
//  - FSM IDLE -> CALC -> FIX -> IDLE.
//  - IDLE, start=1, op=MULT..DIVU: latch |operands| (magnitudes for signed ops) and result signs; go CALC.
//  - CALC: exactly WIDTH cycles; one shift-add (mul) or restoring shift-subtract (div) step per cycle.
//  - FIX: one cycle; apply sign correction and write hi/lo on the edge leaving FIX; done=1 the following cycle.
//  - Latency: start edge T -> busy=1 for cycles T+1..T+WIDTH+1; hi/lo updated and done=1 after edge T+WIDTH+1.
//  - done is high exactly one cycle with busy=0; a new start in that cycle is accepted.
//  - MTHI/MTLO: hi (or lo) <= rs_val on the accepting edge; no busy, no done.
//  - op 11x: ignored, no state change.
//  - start while busy=1: ignored, no queuing.
//  - Signed mul: 2W-bit product negated if signs differ.
//  - Signed div: quotient negative if signs differ; remainder takes the dividend's sign.
//  - Divide by zero: lo=all-ones, hi=dividend (rs_val unmodified); full latency still taken.
//  - Signed overflow (most-negative / -1): lo=most-negative, hi=0.
//  - hi/lo never change during CALC/FIX; intermediate state lives in private registers.
//  - flush=1: FSM->IDLE next edge, busy=0, no done, hi/lo unchanged.
//  - flush on the same edge as start: flush wins, start (incl. MTHI/MTLO) discarded.
//  - Reset mid-operation: immediate return to reset values; result lost.
// CONFIGURATION
//  MULDIV_DIVIDE_EN defined:
//   - DIV/DIVU implemented as above.
//  MULDIV_DIVIDE_EN undefined:
//   - Divider datapath removed.
//   - DIV/DIVU accepted, busy stays 0, done pulses the cycle after acceptance, hi/lo unchanged.
//  - MULT/MULTU/MTHI/MTLO behave identically in both builds.
// TESTING
//  1. MULTU rs=FFFFFFFF rt=FFFFFFFF -> done at T+33: hi=FFFFFFFE lo=00000001; busy high 32+1 cycles.
//  2. MULT rs=FFFFFFFD(-3) rt=00000005 -> hi=FFFFFFFF lo=FFFFFFF1.
//  3. DIV rs=FFFFFFF9(-7) rt=00000002 -> lo=FFFFFFFD hi=FFFFFFFF.
//     DIV 80000000 / FFFFFFFF -> lo=80000000 hi=00000000.
//  4. DIVU rs=00000064 rt=0 -> lo=FFFFFFFF hi=00000064.
//     Without MULDIV_DIVIDE_EN: done at T+1, hi/lo unchanged.
//  5. MTHI 00001234, then MULT 2*3, flush at CALC cycle 10 -> busy=0 next cycle, no done, hi=00001234.
//     Second start during busy is ignored.
//  6. rst_n low mid-CALC -> hi=lo=0, busy=done=0 asynchronously.
//     Back-to-back start in the done cycle is accepted.

Source files
------------

// File: rtl/hilo_muldiv_if.sv
// Request/response bundle between decode and the HI/LO multiply/divide unit.
// master: decode side (issues start/op/operands/flush); slave: the unit.
interface hilo_muldiv_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, rs_val, rt_val, flush,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, rs_val, rt_val, flush,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// Iterative multiply/divide engine owning the architectural HI/LO registers.
// One shift-add (multiply) or restoring shift-subtract (divide) step per cycle,
// WIDTH steps, then one sign-fixup cycle that writes HI/LO.
// Build option: define MULDIV_DIVIDE_EN to include the divider datapath; without
// it DIV/DIVU are accepted as single-cycle no-ops that only pulse done.
module hilo_muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input logic           clk,
    input logic           rst_n,
    hilo_muldiv_if.slave  bus
);
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             done_q;

    // Private working registers; HI/LO are only written when leaving FIX.
    logic [WIDTH-1:0] acc_hi;   // partial product high half / partial remainder
    logic [WIDTH-1:0] acc_lo;   // multiplier bits / dividend bits -> quotient
    logic [WIDTH-1:0] opnd;     // multiplicand / divisor magnitude
    logic             neg_res;  // negate product, or negate quotient
`ifdef MULDIV_DIVIDE_EN
    logic             is_div;
    logic             neg_rem;
    logic             div_zero;
`endif

    logic             accept, start_calc, last;
    logic             op_mul, op_div, op_mthi, op_mtlo, op_signed;
    logic             sign_a, sign_b;
    logic [WIDTH-1:0] mag_a, mag_b;

    assign op_mul    = (bus.op[2:1] == 2'b00);
    assign op_div    = (bus.op[2:1] == 2'b01);
    assign op_mthi   = (bus.op == 3'b100);
    assign op_mtlo   = (bus.op == 3'b101);
    assign op_signed = ~bus.op[0];
    assign sign_a    = op_signed & bus.rs_val[WIDTH-1];
    assign sign_b    = op_signed & bus.rt_val[WIDTH-1];
    assign mag_a     = sign_a ? (~bus.rs_val + WIDTH'(1)) : bus.rs_val;
    assign mag_b     = sign_b ? (~bus.rt_val + WIDTH'(1)) : bus.rt_val;

    assign accept = (state == IDLE) && bus.start && !bus.flush;
`ifdef MULDIV_DIVIDE_EN
    assign start_calc = accept && (op_mul || op_div);
`else
    assign start_calc = accept && op_mul;
`endif
    assign last = (count == CNT_W'(WIDTH - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic; flush overrides every transition
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_calc) state_next = CALC;
            CALC:    if (last)       state_next = FIX;
            FIX:                     state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
        if (bus.flush) state_next = IDLE;
    end

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] step_hi, step_lo;
`ifdef MULDIV_DIVIDE_EN
    logic [WIDTH:0]   div_shift, div_diff;
`endif

    // One iteration step of the shared accumulator pair
    always_comb begin
        mul_sum = {1'b0, acc_hi} + {1'b0, opnd & {WIDTH{acc_lo[0]}}};
        step_hi = mul_sum[WIDTH:1];
        step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
`ifdef MULDIV_DIVIDE_EN
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd};
        if (is_div) begin
            if (!div_diff[WIDTH]) begin
                step_hi = div_diff[WIDTH-1:0];
                step_lo = {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                step_hi = div_shift[WIDTH-1:0];
                step_lo = {acc_lo[WIDTH-2:0], 1'b0};
            end
        end
`endif
    end

    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   fix_hi, fix_lo;

    // Sign correction applied in FIX
    always_comb begin
        prod     = {acc_hi, acc_lo};
        prod_fix = neg_res ? (~prod + (2*WIDTH)'(1)) : prod;
        fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
        fix_lo   = prod_fix[WIDTH-1:0];
`ifdef MULDIV_DIVIDE_EN
        // Divide by zero: the restoring loop with a zero divisor shifts the whole
        // dividend magnitude into the remainder, so re-signing it yields rs_val;
        // only the quotient needs overriding.
        if (is_div) begin
            fix_hi = neg_rem ? (~acc_hi + WIDTH'(1)) : acc_hi;
            if (div_zero)     fix_lo = '1;
            else if (neg_res) fix_lo = ~acc_lo + WIDTH'(1);
            else              fix_lo = acc_lo;
        end
`endif
    end

    // Datapath: operand latch, iteration, HI/LO writeback and done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            count   <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            opnd    <= '0;
            neg_res <= 1'b0;
`ifdef MULDIV_DIVIDE_EN
            is_div   <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                if (op_mthi) hi_q <= bus.rs_val;
                if (op_mtlo) lo_q <= bus.rs_val;
`ifndef MULDIV_DIVIDE_EN
                if (op_div) done_q <= 1'b1;
`endif
                if (start_calc) begin
                    count   <= '0;
                    acc_hi  <= '0;
                    neg_res <= sign_a ^ sign_b;
`ifdef MULDIV_DIVIDE_EN
                    is_div   <= op_div;
                    neg_rem  <= sign_a;
                    div_zero <= (bus.rt_val == '0);
                    if (op_div) begin
                        acc_lo <= mag_a;
                        opnd   <= mag_b;
                    end else begin
                        acc_lo <= mag_b;
                        opnd   <= mag_a;
                    end
`else
                    acc_lo <= mag_b;
                    opnd   <= mag_a;
`endif
                end
            end else if (state == CALC && !bus.flush) begin
                acc_hi <= step_hi;
                acc_lo <= step_lo;
                count  <= count + 1'b1;
            end else if (state == FIX && !bus.flush) begin
                hi_q   <= fix_hi;
                lo_q   <= fix_lo;
                done_q <= 1'b1;
            end
        end
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed testbench for hilo_muldiv_unit (default build or MULDIV_DIVIDE_EN).
module tb_hilo_muldiv_unit;
    localparam int unsigned W = 32;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;

    hilo_muldiv_if #(.WIDTH(W)) bus ();

    hilo_muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a negedge: holds start for one rising edge, returns at the next negedge
    task automatic start_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start  = 1'b1;
        bus.op     = o;
        bus.rs_val = a;
        bus.rt_val = b;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Waits (bounded) for done, counting negedges and busy-high samples
    task automatic wait_done(output int cyc, output int nbusy);
        cyc   = 0;
        nbusy = 0;
        while (bus.done !== 1'b1 && cyc < 200) begin
            if (bus.busy === 1'b1) nbusy++;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_total++; if (bus.hi !== 32'h0)  $display("FAIL reset_hi got %h want 00000000", bus.hi);  else n_pass++;
        n_total++; if (bus.lo !== 32'h0)  $display("FAIL reset_lo got %h want 00000000", bus.lo);  else n_pass++;
        n_total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy);    else n_pass++;
        n_total++; if (bus.done !== 1'b0) $display("FAIL reset_done got %b want 0", bus.done);    else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_multu();
        int cyc, nb;
        start_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(cyc, nb);
        n_total++; if (cyc != 33) $display("FAIL multu_latency got %0d want 33", cyc); else n_pass++;
        n_total++; if (nb != 33)  $display("FAIL multu_busy_cycles got %0d want 33", nb); else n_pass++;
        n_total++; if (bus.hi !== 32'hFFFF_FFFE) $display("FAIL multu_hi got %h want FFFFFFFE", bus.hi); else n_pass++;
        n_total++; if (bus.lo !== 32'h0000_0001) $display("FAIL multu_lo got %h want 00000001", bus.lo); else n_pass++;
        n_total++; if (bus.busy !== 1'b0) $display("FAIL multu_busy_at_done got %b want 0", bus.busy); else n_pass++;
        @(negedge clk);
        n_total++; if (bus.done !== 1'b0) $display("FAIL multu_done_width got %b want 0", bus.done); else n_pass++;
    endtask

    task automatic test_mult();
        int cyc, nb;
        start_op(3'b000, 32'hFFFF_FFFD, 32'h0000_0005);
        wait_done(cyc, nb);
        n_total++; if (cyc != 33) $display("FAIL mult_latency got %0d want 33", cyc); else n_pass++;
        n_total++; if (bus.hi !== 32'hFFFF_FFFF) $display("FAIL mult_hi got %h want FFFFFFFF", bus.hi); else n_pass++;
        n_total++; if (bus.lo !== 32'hFFFF_FFF1) $display("FAIL mult_lo got %h want FFFFFFF1", bus.lo); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_divide();
        int cyc, nb;
`ifdef MULDIV_DIVIDE_EN
        start_op(3'b010, 32'hFFFF_FFF9, 32'h0000_0002);
        wait_done(cyc, nb);
        n_total++; if (cyc != 33) $display("FAIL div_latency got %0d want 33", cyc); else n_pass++;
        n_total++; if (bus.lo !== 32'hFFFF_FFFD) $display("FAIL div_lo got %h want FFFFFFFD", bus.lo); else n_pass++;
        n_total++; if (bus.hi !== 32'hFFFF_FFFF) $display("FAIL div_hi got %h want FFFFFFFF", bus.hi); else n_pass++;
        @(negedge clk);
        start_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(cyc, nb);
        n_total++; if (bus.lo !== 32'h8000_0000) $display("FAIL div_ovf_lo got %h want 80000000", bus.lo); else n_pass++;
        n_total++; if (bus.hi !== 32'h0000_0000) $display("FAIL div_ovf_hi got %h want 00000000", bus.hi); else n_pass++;
        @(negedge clk);
        start_op(3'b011, 32'h0000_0064, 32'h0000_0000);
        wait_done(cyc, nb);
        n_total++; if (cyc != 33) $display("FAIL divz_latency got %0d want 33", cyc); else n_pass++;
        n_total++; if (bus.lo !== 32'hFFFF_FFFF) $display("FAIL divz_lo got %h want FFFFFFFF", bus.lo); else n_pass++;
        n_total++; if (bus.hi !== 32'h0000_0064) $display("FAIL divz_hi got %h want 00000064", bus.hi); else n_pass++;
        @(negedge clk);
        start_op(3'b010, 32'hFFFF_FFF9, 32'h0000_0000);
        wait_done(cyc, nb);
        n_total++; if (bus.lo !== 32'hFFFF_FFFF) $display("FAIL divz_s_lo got %h want FFFFFFFF", bus.lo); else n_pass++;
        n_total++; if (bus.hi !== 32'hFFFF_FFF9) $display("FAIL divz_s_hi got %h want FFFFFFF9", bus.hi); else n_pass++;
        @(negedge clk);
`else
        // hi/lo still hold the MULT result FFFFFFFF/FFFFFFF1
        start_op(3'b011, 32'h0000_0064, 32'h0000_0000);
        n_total++; if (bus.busy !== 1'b0) $display("FAIL nodiv_busy got %b want 0", bus.busy); else n_pass++;
        n_total++; if (bus.done !== 1'b1) $display("FAIL nodiv_done got %b want 1", bus.done); else n_pass++;
        @(negedge clk);
        n_total++; if (bus.done !== 1'b0) $display("FAIL nodiv_done_width got %b want 0", bus.done); else n_pass++;
        n_total++; if (bus.hi !== 32'hFFFF_FFFF) $display("FAIL nodiv_hi got %h want FFFFFFFF", bus.hi); else n_pass++;
        n_total++; if (bus.lo !== 32'hFFFF_FFF1) $display("FAIL nodiv_lo got %h want FFFFFFF1", bus.lo); else n_pass++;
        cyc = 0;
        nb  = 0;
`endif
    endtask

    task automatic test_flush();
        int seen;
        start_op(3'b100, 32'h0000_1234, 32'h0);
        n_total++; if (bus.hi !== 32'h0000_1234) $display("FAIL mthi_hi got %h want 00001234", bus.hi); else n_pass++;
        n_total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0)
            $display("FAIL mthi_handshake got busy=%b done=%b want 0 0", bus.busy, bus.done); else n_pass++;
        start_op(3'b101, 32'h0000_ABCD, 32'h0);
        n_total++; if (bus.lo !== 32'h0000_ABCD) $display("FAIL mtlo_lo got %h want 0000ABCD", bus.lo); else n_pass++;
        start_op(3'b000, 32'h0000_0002, 32'h0000_0003);
        repeat (9) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        n_total++; if (bus.busy !== 1'b0) $display("FAIL flush_busy got %b want 0", bus.busy); else n_pass++;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done === 1'b1) seen++;
            @(negedge clk);
        end
        n_total++; if (seen != 0) $display("FAIL flush_no_done got %0d pulses want 0", seen); else n_pass++;
        n_total++; if (bus.hi !== 32'h0000_1234) $display("FAIL flush_hi got %h want 00001234", bus.hi); else n_pass++;
        n_total++; if (bus.lo !== 32'h0000_ABCD) $display("FAIL flush_lo got %h want 0000ABCD", bus.lo); else n_pass++;
        // flush coincident with start discards even MTLO
        bus.flush = 1'b1;
        start_op(3'b101, 32'h0000_5555, 32'h0);
        bus.flush = 1'b0;
        n_total++; if (bus.lo !== 32'h0000_ABCD) $display("FAIL flush_start_lo got %h want 0000ABCD", bus.lo); else n_pass++;
    endtask

    task automatic test_ignored();
        int cyc, nb;
        start_op(3'b001, 32'h0000_0003, 32'h0000_0004);
        repeat (3) @(negedge clk);
        start_op(3'b100, 32'h0000_DEAD, 32'h0);
        n_total++; if (bus.hi !== 32'h0000_1234) $display("FAIL busy_start_hi got %h want 00001234", bus.hi); else n_pass++;
        wait_done(cyc, nb);
        n_total++; if (cyc != 29) $display("FAIL busy_start_latency got %0d want 29", cyc); else n_pass++;
        n_total++; if (bus.hi !== 32'h0000_0000) $display("FAIL busy_start_res_hi got %h want 00000000", bus.hi); else n_pass++;
        n_total++; if (bus.lo !== 32'h0000_000C) $display("FAIL busy_start_res_lo got %h want 0000000C", bus.lo); else n_pass++;
        @(negedge clk);
        start_op(3'b110, 32'h1111_1111, 32'h0000_0002);
        n_total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0)
            $display("FAIL nop_handshake got busy=%b done=%b want 0 0", bus.busy, bus.done); else n_pass++;
        start_op(3'b111, 32'h2222_2222, 32'h0000_0002);
        n_total++; if (bus.busy !== 1'b0) $display("FAIL nop111_busy got %b want 0", bus.busy); else n_pass++;
        n_total++; if (bus.hi !== 32'h0 || bus.lo !== 32'h0000_000C)
            $display("FAIL nop_hilo got %h/%h want 00000000/0000000C", bus.hi, bus.lo); else n_pass++;
    endtask

    task automatic test_reset_mid();
        start_op(3'b100, 32'h0000_0077, 32'h0);
        start_op(3'b001, 32'h0000_0007, 32'h0000_0009);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_total++; if (bus.hi !== 32'h0) $display("FAIL rst_mid_hi got %h want 00000000", bus.hi); else n_pass++;
        n_total++; if (bus.lo !== 32'h0) $display("FAIL rst_mid_lo got %h want 00000000", bus.lo); else n_pass++;
        n_total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0)
            $display("FAIL rst_mid_handshake got busy=%b done=%b want 0 0", bus.busy, bus.done); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int cyc, nb;
        start_op(3'b001, 32'h0000_0006, 32'h0000_0007);
        wait_done(cyc, nb);
        n_total++; if (bus.lo !== 32'h0000_002A) $display("FAIL b2b_first_lo got %h want 0000002A", bus.lo); else n_pass++;
        start_op(3'b001, 32'h0001_0000, 32'h0001_0000);
        n_total++; if (bus.busy !== 1'b1) $display("FAIL b2b_accept_busy got %b want 1", bus.busy); else n_pass++;
        wait_done(cyc, nb);
        n_total++; if (cyc != 33) $display("FAIL b2b_latency got %0d want 33", cyc); else n_pass++;
        n_total++; if (bus.hi !== 32'h0000_0001 || bus.lo !== 32'h0)
            $display("FAIL b2b_result got %h/%h want 00000001/00000000", bus.hi, bus.lo); else n_pass++;
        @(negedge clk);
    endtask

    initial begin
        n_pass     = 0;
        n_total    = 0;
        bus.start  = 1'b0;
        bus.op     = 3'b000;
        bus.rs_val = '0;
        bus.rt_val = '0;
        bus.flush  = 1'b0;
        test_reset();
        test_multu();
        test_mult();
        test_divide();
        test_flush();
        test_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
